inta_cycle_master: RTL and testbench
====================================

Name: inta_cycle_master

Overview:
- CPU-side initiator of the 8259A INT/INTA handshake, the other end of the priority resolver's INT output and INTA input.
- When the PIC raises INT and the CPU is accepting interrupts, it generates the two-pulse 8086-mode INTA_n sequence.
- It captures the 8-bit vector driven on the data bus during the second pulse and hands that vector to the CPU model as a one-cycle strobe.
- It sits in the bench/SoC wrapper between the PIC top level and the CPU stub.

Parameters:
- INTA_LOW_CYCLES, 2, clk cycles each INTA_n pulse is held low (legal 1..15).
- INTA_GAP_CYCLES, 2, clk cycles INTA_n is high between pulse 1 and pulse 2 (legal 1..15).
- LOCKOUT_CYCLES, 4, clk cycles after vector capture during which a new INT is ignored (legal 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- INT  input  1  interrupt request from PIC; asynchronous, active high.
- int_enable  input  1  CPU interrupt flag; sequence may start only while 1.
- D_in  input  8  PIC data bus, sampled during pulse 2.
- INTA_n  output  1  interrupt acknowledge to PIC, active low.
- vector  output  8  last captured vector; holds until the next capture.
- vector_valid  output  1  one-cycle strobe when vector updates.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous:
  - INTA_n=1, vector=8'h00, vector_valid=0, busy=0.
  - State=IDLE, counter=0, synchronizer flops=0.
- INT passes through a 2-flop synchronizer giving int_s; the FSM uses only int_s.
- Counter is 4 bits, loaded on each state entry and decremented each cycle; a state exits when the counter reaches 1.
- States:
  - IDLE: if int_s=1 and int_enable=1, go to ACK1. The first INTA_n low appears on the cycle after that decision. Latency from INT rise to INTA_n fall is 3 clk.
  - ACK1: INTA_n=0 for INTA_LOW_CYCLES, then go to GAP. D_in is ignored.
  - GAP: INTA_n=1 for INTA_GAP_CYCLES, then go to ACK2.
  - ACK2: INTA_n=0 for INTA_LOW_CYCLES. D_in is registered into vector on the last low cycle. The FSM then goes to LOCK.
  - LOCK:
    - INTA_n=1.
    - vector_valid=1 on the first LOCK cycle only.
    - Stays for LOCKOUT_CYCLES, then goes to IDLE.
- INTA_n and vector_valid are registered outputs (no combinational glitch). busy is decoded from state.
- Once ACK1 is entered the sequence always completes both pulses, even if int_s drops or int_enable falls mid-sequence. Whatever D_in holds is captured; this is the PIC spurious-IR7 case, and D_in is not validated.
- int_enable is sampled only in IDLE.
- If INT is still high at the end of LOCK, a new sequence starts immediately from IDLE. This is the back-to-back request case: the next INTA_n fall comes 1 clk after IDLE is entered.
- INT pulses shorter than 2 clk may be missed. This is acceptable because the PIC holds INT until acknowledged.
- If rst_n is asserted mid-pulse, INTA_n returns to 1 immediately (asynchronous) and vector is cleared.
- Parameter values of 0 are illegal and are caught by an elaboration-time check.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum typedef (IDLE, ACK1, GAP, ACK2, LOCK);
  - the default timing constants;
  - VECTOR_W=8.
- One natural sub-module: sync_2ff, a generic 1-bit two-flop synchronizer with asynchronous active-low reset. It is reusable for the PIC's IR inputs.

Test Plan:
- Reset with INT=1 held: INTA_n stays 1, vector=00, busy=0 throughout reset; the first INTA_n fall is 3 clk after rst_n deasserts.
- INT=1, int_enable=1, D_in=8'h4B during pulse 2, defaults:
  - INTA_n is low 2 clk, high 2 clk, low 2 clk.
  - vector=4B with vector_valid high for exactly 1 clk.
  - busy stays high 4 clk longer.
- INT=1 with int_enable=0 for 20 clk: no INTA_n activity. Raising int_enable starts the sequence 1 clk later.
- INT dropped during GAP, D_in=8'h3F: pulse 2 still occurs, vector=3F, and the FSM returns to IDLE after LOCK with no further pulses.
- INT held high continuously with D_in=8'h20 and then 8'h21: two complete sequences; vector_valid pulses twice, with values 20 then 21.
- rst_n asserted during ACK2 low: INTA_n goes to 1 within the same cycle, vector=00, no vector_valid pulse; a clean sequence follows after release.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and timing defaults for the PIC/CPU INTA handshake.
// Holds the handshake FSM state encoding and the vector width.
package pic_pkg;

  localparam int VECTOR_W     = 8;
  localparam int INTA_LOW_DEF = 2;
  localparam int INTA_GAP_DEF = 2;
  localparam int LOCKOUT_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    LOCK
  } state_t;

endpackage

// File: rtl/inta_cycle_master_if.sv
// INT/INTA bundle between the PIC, this master and the CPU stub.
// master: INT/int_enable/D_in in; INTA_n/vector/vector_valid/busy out.
interface inta_cycle_master_if;
  import pic_pkg::*;

  logic                INT;
  logic                int_enable;
  logic [VECTOR_W-1:0] D_in;
  logic                INTA_n;
  logic [VECTOR_W-1:0] vector;
  logic                vector_valid;
  logic                busy;

  modport master (
    input  INT, int_enable, D_in,
    output INTA_n, vector, vector_valid, busy
  );

  modport slave (
    output INT, int_enable, D_in,
    input  INTA_n, vector, vector_valid, busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inta_cycle_master.sv
// CPU-side 8086-mode INTA master: two INTA_n pulses, vector capture.
// Ports: clk, rst_n, bus (master modport of inta_cycle_master_if).
module inta_cycle_master
  import pic_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = INTA_LOW_DEF,
  parameter int INTA_GAP_CYCLES = INTA_GAP_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  inta_cycle_master_if.master bus
);

  if (INTA_LOW_CYCLES < 1 || INTA_LOW_CYCLES > 15) begin : g_bad_low
    $error("INTA_LOW_CYCLES out of range 1..15");
  end
  if (INTA_GAP_CYCLES < 1 || INTA_GAP_CYCLES > 15) begin : g_bad_gap
    $error("INTA_GAP_CYCLES out of range 1..15");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 15) begin : g_bad_lock
    $error("LOCKOUT_CYCLES out of range 1..15");
  end

  localparam logic [3:0] LOW_C  = 4'(INTA_LOW_CYCLES);
  localparam logic [3:0] GAP_C  = 4'(INTA_GAP_CYCLES);
  localparam logic [3:0] LOCK_C = 4'(LOCKOUT_CYCLES);

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       int_s;
  logic       last;
  logic       inta_d;
  logic       vv_d;
  logic       cap;

  function automatic logic [3:0] dur(input state_t s);
    unique case (s)
      ACK1, ACK2: dur = LOW_C;
      GAP:        dur = GAP_C;
      LOCK:       dur = LOCK_C;
      default:    dur = 4'd0;
    endcase
  endfunction

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.INT),
    .q     (int_s)
  );

  assign last = (cnt == 4'd1);

  // Counter reloads on every state change, else counts down to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= dur(nxt);
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (int_s && bus.int_enable) nxt = ACK1;
      ACK1: if (last) nxt = GAP;
      GAP:  if (last) nxt = ACK2;
      ACK2: if (last) nxt = LOCK;
      LOCK: if (last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are computed from nxt so the flops line up with the state.
  always_comb begin
    inta_d = !((nxt == ACK1) || (nxt == ACK2));
    vv_d   = (nxt == LOCK) && (state != LOCK);
    cap    = (state == ACK2) && last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.INTA_n       <= 1'b1;
      bus.vector_valid <= 1'b0;
      bus.vector       <= '0;
    end else begin
      bus.INTA_n       <= inta_d;
      bus.vector_valid <= vv_d;
      if (cap)
        bus.vector <= bus.D_in;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_inta_cycle_master.sv
// Directed bench for inta_cycle_master.
// Checks pulse timing, vector capture, lockout and reset behaviour.
module tb_inta_cycle_master;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  inta_cycle_master_if bus ();

  inta_cycle_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] o,
                     input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic look(input logic ei, input logic eb, input logic ev,
                      input logic [7:0] evec, input string tag);
    chk({tag, "/inta"}, {7'b0, bus.INTA_n}, {7'b0, ei});
    chk({tag, "/busy"}, {7'b0, bus.busy}, {7'b0, eb});
    chk({tag, "/vv"}, {7'b0, bus.vector_valid}, {7'b0, ev});
    chk({tag, "/vec"}, bus.vector, evec);
  endtask

  task automatic cyc(input logic ei, input logic eb, input logic ev,
                     input logic [7:0] evec, input string tag);
    @(posedge clk);
    #1;
    look(ei, eb, ev, evec, tag);
  endtask

  // Full sequence from the first ACK1 cycle to the last LOCK cycle.
  task automatic run_seq(input logic [7:0] prev, input logic [7:0] dv,
                         input logic drop);
    cyc(0, 1, 0, prev, "ack1a");
    cyc(0, 1, 0, prev, "ack1b");
    cyc(1, 1, 0, prev, "gapa");
    if (drop) bus.INT = 1'b0;
    cyc(1, 1, 0, prev, "gapb");
    bus.D_in = dv;
    cyc(0, 1, 0, prev, "ack2a");
    cyc(0, 1, 0, prev, "ack2b");
    cyc(1, 1, 1, dv, "lock0");
    cyc(1, 1, 0, dv, "lock1");
    cyc(1, 1, 0, dv, "lock2");
    cyc(1, 1, 0, dv, "lock3");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.INT = 1'b1;
    bus.int_enable = 1'b1;
    bus.D_in = 8'h00;

    // Reset held with INT high.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, "inrst");
    rst_n = 1'b1;
    cyc(1, 0, 0, 8'h00, "lat1");
    cyc(1, 0, 0, 8'h00, "lat2");
    run_seq(8'h00, 8'h4B, 1'b1);
    cyc(1, 0, 0, 8'h4B, "idle1");
    cyc(1, 0, 0, 8'h4B, "idle1b");

    // Interrupts disabled: no activity.
    bus.int_enable = 1'b0;
    bus.INT = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 8'h4B, "dis");
    bus.int_enable = 1'b1;
    // INT dropped during GAP; pulse 2 still happens.
    run_seq(8'h4B, 8'h3F, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'h3F, "nomore");

    // Back-to-back with INT held.
    bus.INT = 1'b1;
    cyc(1, 0, 0, 8'h3F, "b2b_s1");
    cyc(1, 0, 0, 8'h3F, "b2b_s2");
    run_seq(8'h3F, 8'h20, 1'b0);
    cyc(1, 0, 0, 8'h20, "b2b_idle");
    run_seq(8'h20, 8'h21, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h21, "b2b_end");

    // Reset during ACK2 low.
    bus.INT = 1'b1;
    cyc(1, 0, 0, 8'h21, "r_s1");
    cyc(1, 0, 0, 8'h21, "r_s2");
    cyc(0, 1, 0, 8'h21, "r_ack1a");
    cyc(0, 1, 0, 8'h21, "r_ack1b");
    cyc(1, 1, 0, 8'h21, "r_gapa");
    cyc(1, 1, 0, 8'h21, "r_gapb");
    bus.D_in = 8'h77;
    cyc(0, 1, 0, 8'h21, "r_ack2a");
    #3;
    rst_n = 1'b0;
    #1;
    look(1, 0, 0, 8'h00, "r_async");
    cyc(1, 0, 0, 8'h00, "r_hold1");
    cyc(1, 0, 0, 8'h00, "r_hold2");
    rst_n = 1'b1;
    cyc(1, 0, 0, 8'h00, "r_lat1");
    cyc(1, 0, 0, 8'h00, "r_lat2");
    run_seq(8'h00, 8'h5A, 1'b1);
    cyc(1, 0, 0, 8'h5A, "r_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
